// File: rtl/box_gray_capture.sv
// box_gray_capture: takes in-box RGB565 pixels from the byte-rate camera stream,
// converts them to 8-bit grayscale through a two-stage pipeline and writes one
// BOX_W x BOX_W frame row-major into the CNN input buffer. The completed frame is
// then held (frame_ready) until the CNN acknowledges it; camera frames arriving
// meanwhile are skipped.
module box_gray_capture #(
    parameter int BOX_W  = 50,
    parameter int ADDR_W = 12
) (
    input  logic              cam_pclk,
    input  logic              rst,
    input  logic              pos_vsync,
    input  logic              gray_en,
    input  logic [15:0]       cmos_data_t,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_ready,
    input  logic              frame_ack
);
    localparam int                NPIX     = BOX_W * BOX_W;
    localparam int                STAGES   = 2;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    // first pipeline stage: weighted colour channels plus destination address
    typedef struct packed {
        logic [15:0]       r_p;
        logic [15:0]       g_p;
        logic [15:0]       b_p;
        logic [ADDR_W-1:0] addr;
    } s1_t;

    state_t              state, state_nxt;
    logic                phase;
    logic [ADDR_W-1:0]   pix_cnt, pix_cnt_nxt;
    logic                flush_cnt, flush_cnt_nxt;
    logic                take;
    logic [STAGES:1]     vld_pipe;
    s1_t                 s1;
    logic [7:0]          r8, g8, b8;
    logic [15:0]         y_sum;

    // a frame-start pulse wins over a coincident pixel: the restart discards it
    assign take = (state == CAPTURE) && gray_en && phase && !pos_vsync;

    // channel expansion to 8 bits by replicating the top bits into the low bits
    assign r8 = {cmos_data_t[15:11], cmos_data_t[15:13]};
    assign g8 = {cmos_data_t[10:5],  cmos_data_t[10:9]};
    assign b8 = {cmos_data_t[4:0],   cmos_data_t[4:2]};

    // weights sum to 256, so the total peaks at 255*256 and fits 16 bits
    assign y_sum = s1.r_p + s1.g_p + s1.b_p;

    assign frame_ready = (state == DONE);

    // state, pixel counter, flush counter and byte phase registers
    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            flush_cnt <= 1'b0;
            phase     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pix_cnt   <= pix_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            phase     <= gray_en ? ~phase : 1'b0;
        end
    end

    // next-state logic: arm on vsync, count taken pixels, drain, hold until ack
    always_comb begin
        state_nxt     = state;
        pix_cnt_nxt   = pix_cnt;
        flush_cnt_nxt = flush_cnt;
        case (state)
            IDLE: begin
                if (pos_vsync) begin
                    state_nxt   = CAPTURE;
                    pix_cnt_nxt = '0;
                end
            end
            CAPTURE: begin
                if (pos_vsync) begin
                    pix_cnt_nxt = '0;
                end else if (take) begin
                    pix_cnt_nxt = pix_cnt + 1'b1;
                    if (pix_cnt == LAST_PIX) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = 1'b0;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_nxt = 1'b1;
                if (flush_cnt) state_nxt = DONE;
            end
            DONE: begin
                if (frame_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // stage 1: channel products and address
    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            s1          <= '0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= take;
            if (take) begin
                s1.r_p  <= 16'(r8) * 16'd77;
                s1.g_p  <= 16'(g8) * 16'd150;
                s1.b_p  <= 16'(b8) * 16'd29;
                s1.addr <= pix_cnt;
            end
        end
    end

    // stage 2: luma sum scaled by 1/256 and buffer write
    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                wr_addr <= s1.addr;
                wr_data <= y_sum[15:8];
            end
        end
    end

    assign wr_en = vld_pipe[STAGES];

endmodule
